// File: rtl/ace_line_req_sched.sv
// Request scheduler for the ACE line FSM: snoop / write / read share one
// strobe set; each grant plays a fixed registered strobe sequence then settles.
module ace_line_req_sched #(
   parameter int HOLD_CYCLES = 2,
   parameter int MAX_SNP     = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic snp_req,
   input  logic wr_req,
   input  logic rd_req,
   input  logic line_invalid,
   output logic snp_gnt,
   output logic wr_gnt,
   output logic rd_gnt,
   output logic snp_done,
   output logic wr_done,
   output logic rd_done,
   output logic acvalid,
   output logic awvalid,
   output logic arvalid,
   output logic crready,
   output logic acsnoop,
   output logic busy
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ALLOC  = 2'd1;
   localparam logic [1:0] S_ISSUE  = 2'd2;
   localparam logic [1:0] S_SETTLE = 2'd3;

   localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);
   localparam logic [3:0] SNP_CAP   = 4'(MAX_SNP);

   // requester vectors are one-hot {rd, wr, snp}
   logic [1:0] state, state_d;
   logic [2:0] sel, sel_d, pick;
   logic [3:0] hold, hold_d;
   logic [3:0] streak, streak_d;
   logic       rr_rd, rr_rd_d;
   logic [2:0] gnt_d, done_d;
   logic       acv_d, awv_d, arv_d, crr_d, acs_d, busy_d;
   logic       rw_pend, any_req, snp_ok, rd_ok;

   assign rw_pend = rd_req | wr_req;
   assign any_req = snp_req | rw_pend;
   assign snp_ok  = snp_req & ~((streak == SNP_CAP) & rw_pend);
   assign rd_ok   = rd_req & (~wr_req | rr_rd);

   always_comb begin
      pick = 3'b000;
      if (snp_ok)      pick = 3'b001;
      else if (rd_ok)  pick = 3'b100;
      else if (wr_req) pick = 3'b010;
   end

   always_comb begin
      state_d  = state;
      sel_d    = sel;
      hold_d   = hold;
      streak_d = streak;
      rr_rd_d  = rr_rd;
      gnt_d    = 3'b000;
      done_d   = 3'b000;
      acv_d    = 1'b0;
      awv_d    = 1'b0;
      arv_d    = 1'b0;
      crr_d    = 1'b0;
      acs_d    = 1'b0;
      busy_d   = 1'b1;
      unique case (state)
         S_IDLE: begin
            busy_d = any_req;
            if (any_req) begin
               sel_d = pick;
               gnt_d = pick;
               if (pick[0]) begin
                  if (rw_pend && streak != SNP_CAP)
                     streak_d = streak + 4'd1;
               end else begin
                  streak_d = 4'd0;
                  rr_rd_d  = pick[1];
               end
               // write to an INVALID line needs an allocate beat first
               if (pick[1] & line_invalid) begin
                  state_d = S_ALLOC;
                  acv_d   = 1'b1;
               end else begin
                  state_d = S_ISSUE;
                  unique case (1'b1)
                     pick[0]: acs_d = 1'b1;
                     pick[1]: begin
                        awv_d = 1'b1;
                        acv_d = 1'b1;
                     end
                     pick[2]: begin
                        arv_d = 1'b1;
                        crr_d = 1'b1;
                     end
                  endcase
               end
            end
         end
         S_ALLOC: begin
            state_d = S_ISSUE;
            awv_d   = 1'b1;
            acv_d   = 1'b1;
         end
         S_ISSUE: begin
            state_d = S_SETTLE;
            done_d  = sel;
            hold_d  = HOLD_LAST;
         end
         S_SETTLE: begin
            if (hold == 4'd0) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end else begin
               hold_d = hold - 4'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         sel      <= 3'b000;
         hold     <= 4'd0;
         streak   <= 4'd0;
         rr_rd    <= 1'b1;
         snp_gnt  <= 1'b0;
         wr_gnt   <= 1'b0;
         rd_gnt   <= 1'b0;
         snp_done <= 1'b0;
         wr_done  <= 1'b0;
         rd_done  <= 1'b0;
         acvalid  <= 1'b0;
         awvalid  <= 1'b0;
         arvalid  <= 1'b0;
         crready  <= 1'b0;
         acsnoop  <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_d;
         sel      <= sel_d;
         hold     <= hold_d;
         streak   <= streak_d;
         rr_rd    <= rr_rd_d;
         snp_gnt  <= gnt_d[0];
         wr_gnt   <= gnt_d[1];
         rd_gnt   <= gnt_d[2];
         snp_done <= done_d[0];
         wr_done  <= done_d[1];
         rd_done  <= done_d[2];
         acvalid  <= acv_d;
         awvalid  <= awv_d;
         arvalid  <= arv_d;
         crready  <= crr_d;
         acsnoop  <= acs_d;
         busy     <= busy_d;
      end
   end

endmodule

// File: tb/tb_ace_line_req_sched.sv
// Bench for ace_line_req_sched: transaction-level plan model checked every
// cycle, plus directed literal checks of sequences and grant orders.
module tb_ace_line_req_sched;

   localparam int H  = 2;
   localparam int MS = 3;
   localparam int SNP = 0;
   localparam int WR  = 1;
   localparam int RD  = 2;

   typedef struct packed {
      logic sg, wg, rg, sd, wd, rd, acv, awv, arv, crr, acs, busy;
   } ow_t;

   logic clk, rst_n;
   logic snp_req, wr_req, rd_req, line_invalid;
   logic snp_gnt, wr_gnt, rd_gnt, snp_done, wr_done, rd_done;
   logic acvalid, awvalid, arvalid, crready, acsnoop, busy;

   ace_line_req_sched #(.HOLD_CYCLES(H), .MAX_SNP(MS)) dut (
      .clk(clk), .rst_n(rst_n),
      .snp_req(snp_req), .wr_req(wr_req), .rd_req(rd_req),
      .line_invalid(line_invalid),
      .snp_gnt(snp_gnt), .wr_gnt(wr_gnt), .rd_gnt(rd_gnt),
      .snp_done(snp_done), .wr_done(wr_done), .rd_done(rd_done),
      .acvalid(acvalid), .awvalid(awvalid), .arvalid(arvalid),
      .crready(crready), .acsnoop(acsnoop), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   ow_t act_w;
   assign act_w = {snp_gnt, wr_gnt, rd_gnt, snp_done, wr_done, rd_done,
                   acvalid, awvalid, arvalid, crready, acsnoop, busy};

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [15:0] act,
                      input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // model: a planned list of output words per granted transaction
   ow_t plan[$];
   int  win_log[$];
   int  m_streak;
   bit  m_rr_rd;
   ow_t exp_w;

   task automatic decide();
      int  win;
      bit  rw;
      ow_t w;
      rw  = rd_req || wr_req;
      win = -1;
      if (snp_req && !(m_streak == MS && rw)) win = SNP;
      else if (rd_req && wr_req) win = m_rr_rd ? RD : WR;
      else if (rd_req) win = RD;
      else if (wr_req) win = WR;
      if (win < 0) return;
      win_log.push_back(win);
      if (win == SNP) begin
         if (rw && m_streak < MS) m_streak++;
      end else begin
         m_streak = 0;
         m_rr_rd  = (win == WR);
      end
      w = '0;
      w.busy = 1'b1;
      w.sg = (win == SNP);
      w.wg = (win == WR);
      w.rg = (win == RD);
      if (win == WR && line_invalid) begin
         w.acv = 1'b1;
         plan.push_back(w);
         w = '0;
         w.busy = 1'b1;
      end
      case (win)
         SNP: w.acs = 1'b1;
         WR: begin w.awv = 1'b1; w.acv = 1'b1; end
         default: begin w.arv = 1'b1; w.crr = 1'b1; end
      endcase
      plan.push_back(w);
      w = '0;
      w.busy = 1'b1;
      w.sd = (win == SNP);
      w.wd = (win == WR);
      w.rd = (win == RD);
      plan.push_back(w);
      w = '0;
      w.busy = 1'b1;
      for (int i = 1; i < H; i++) plan.push_back(w);
      plan.push_back('0);
   endtask

   always @(posedge clk) begin
      if (!rst_n) begin
         plan.delete();
         m_streak = 0;
         m_rr_rd  = 1'b1;
         exp_w    = '0;
      end else begin
         if (plan.size() == 0) decide();
         exp_w = (plan.size() != 0) ? plan.pop_front() : ow_t'('0);
      end
      #1;
      chk("cycle", 16'(act_w), 16'(exp_w));
   end

   task automatic wait_idle();
      int k;
      k = 0;
      while (busy && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (busy) begin
         n_vec++;
         n_err++;
         $display("FAIL idle_timeout busy=%b expected 0", busy);
      end
   endtask

   task automatic serve(input int target, input bit drop_each);
      int k, seen;
      k    = 0;
      seen = win_log.size();
      while (win_log.size() < target && k < 300) begin
         @(negedge clk);
         k++;
         if (drop_each) begin
            while (seen < win_log.size()) begin
               case (win_log[seen])
                  SNP: snp_req = 1'b0;
                  WR:  wr_req  = 1'b0;
                  default: rd_req = 1'b0;
               endcase
               seen++;
            end
         end
      end
      if (win_log.size() < target) begin
         n_vec++;
         n_err++;
         $display("FAIL grant_timeout got %0d grants expected %0d",
                  win_log.size(), target);
      end
      snp_req = 1'b0;
      wr_req  = 1'b0;
      rd_req  = 1'b0;
      wait_idle();
   endtask

   int base;
   int rr_exp[4]  = '{RD, WR, RD, WR};
   int stv_exp[8] = '{SNP, SNP, SNP, RD, SNP, SNP, SNP, WR};
   int pr_exp[2]  = '{SNP, RD};

   initial begin
      rst_n = 1'b0;
      snp_req = 1'b0;
      wr_req = 1'b0;
      rd_req = 1'b0;
      line_invalid = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", 16'(act_w), 16'h0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_no_req", 16'(act_w), 16'h0);

      // read
      rd_req = 1'b1;
      @(negedge clk);
      chk("rd_t1", {rd_gnt, arvalid, crready, awvalid, acvalid, acsnoop},
          16'b111000);
      rd_req = 1'b0;
      @(negedge clk);
      chk("rd_t2_done", {rd_done, rd_gnt, arvalid, busy}, 16'b1001);
      @(negedge clk);
      chk("rd_t3_busy", busy, 16'd1);
      @(negedge clk);
      chk("rd_t4_idle", busy, 16'd0);

      // write to invalid line, then to valid line
      wr_req = 1'b1;
      line_invalid = 1'b1;
      @(negedge clk);
      chk("wr_alloc", {wr_gnt, acvalid, awvalid, arvalid, crready, acsnoop},
          16'b110000);
      wr_req = 1'b0;
      line_invalid = 1'b0;
      @(negedge clk);
      chk("wr_issue", {wr_gnt, acvalid, awvalid, wr_done}, 16'b0110);
      @(negedge clk);
      chk("wr_done", {wr_done, awvalid, busy}, 16'b101);
      wait_idle();
      wr_req = 1'b1;
      @(negedge clk);
      chk("wr_noalloc", {wr_gnt, acvalid, awvalid}, 16'b111);
      wr_req = 1'b0;
      @(negedge clk);
      chk("wr_noalloc_done", wr_done, 16'd1);
      wait_idle();

      // round robin
      base = win_log.size();
      rd_req = 1'b1;
      wr_req = 1'b1;
      serve(base + 4, 1'b0);
      for (int i = 0; i < 4; i++)
         chk("rr_order", 16'(win_log[base+i]), 16'(rr_exp[i]));

      // starvation guard
      base = win_log.size();
      snp_req = 1'b1;
      rd_req = 1'b1;
      wr_req = 1'b1;
      serve(base + 8, 1'b0);
      for (int i = 0; i < 8; i++)
         chk("starve_order", 16'(win_log[base+i]), 16'(stv_exp[i]));

      // async reset during ALLOC
      wr_req = 1'b1;
      line_invalid = 1'b1;
      @(negedge clk);
      chk("rst_pre_alloc", {wr_gnt, acvalid, awvalid}, 16'b110);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async_zero", 16'(act_w), 16'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_fresh_gnt", {wr_gnt, acvalid, awvalid, wr_done}, 16'b1100);
      wr_req = 1'b0;
      line_invalid = 1'b0;
      @(negedge clk);
      chk("rst_fresh_issue", {acvalid, awvalid, wr_done}, 16'b110);
      @(negedge clk);
      chk("rst_fresh_done", wr_done, 16'd1);
      wait_idle();

      // lone snoop, then rd+snp pair
      snp_req = 1'b1;
      @(negedge clk);
      chk("snp_issue", {snp_gnt, acsnoop, acvalid, awvalid}, 16'b1100);
      snp_req = 1'b0;
      @(negedge clk);
      chk("snp_done", {snp_done, acsnoop}, 16'b10);
      wait_idle();
      chk("model_streak_zero", 16'(m_streak), 16'd0);
      base = win_log.size();
      snp_req = 1'b1;
      rd_req = 1'b1;
      serve(base + 2, 1'b1);
      for (int i = 0; i < 2; i++)
         chk("pair_order", 16'(win_log[base+i]), 16'(pr_exp[i]));

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
